// File: rtl/iir_sched_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade scheduler.
package iir_sched_pkg;

    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned ACC_W_DEF = 36;
    localparam int unsigned NUM_TAPS  = 5;

    localparam logic [2:0] IDX_A0  = 3'd0;
    localparam logic [2:0] IDX_A1  = 3'd1;
    localparam logic [2:0] IDX_A2  = 3'd2;
    localparam logic [2:0] IDX_B1  = 3'd3;
    localparam logic [2:0] IDX_B2  = 3'd4;
    localparam logic [2:0] IDX_SHR = 3'd5;
    localparam logic [2:0] IDX_SHL = 3'd6;
    localparam logic [2:0] IDX_BAD = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWb,
        StDone
    } state_e;

endpackage

// File: rtl/iir_mac_unit.sv
// Shared signed multiply-accumulate: combinational product, registered accumulator.
module iir_mac_unit
    import iir_sched_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    sub,
    input  logic signed [DW-1:0]    coef,
    input  logic signed [DW-1:0]    data,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        prod     = coef * data;
        prod_ext = ACC_W'(prod);
        // Clear folds into the first tap so no idle cycle is spent zeroing.
        base     = clr ? '0 : acc_q;
        acc_d    = acc_q;
        if (en) begin
            acc_d = sub ? (base - prod_ext) : (base + prod_ext);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/iir_biquad_sched.sv
// Cascade of NSEC biquad sections sequenced through one shared MAC, 5 taps plus
// one writeback cycle per section.
module iir_biquad_sched
    import iir_sched_pkg::*;
#(
    parameter int unsigned NSEC  = 2,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [DW-1:0]        cfg_wdata,
    output logic                 cfg_err,
    input  logic                 hist_clr
);

    state_e state_q, state_d;
    logic [2:0]           tap_q;
    logic [2:0]           sec_q;
    logic signed [DW-1:0] sec_in_q;
    logic signed [DW-1:0] dout_q;
    logic                 overrun_q;
    logic                 cfg_err_q;

    logic signed [DW-1:0] coef_q [NSEC][NUM_TAPS];
    logic [4:0]           shr_q  [NSEC];
    logic [3:0]           shl_q  [NSEC];
    logic signed [DW-1:0] x1_q   [NSEC];
    logic signed [DW-1:0] x2_q   [NSEC];
    logic signed [DW-1:0] y1_q   [NSEC];
    logic signed [DW-1:0] y2_q   [NSEC];

    logic signed [DW-1:0] cur_coef [NUM_TAPS];
    logic [4:0]           cur_shr;
    logic [3:0]           cur_shl;
    logic signed [DW-1:0] cur_x1, cur_x2, cur_y1, cur_y2;

    logic signed [DW-1:0]    mac_coef, mac_data;
    logic                    mac_en, mac_clr, mac_sub;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW-1:0]    y_wb, out_wb;

    logic [2:0] cfg_sec, cfg_idx;
    logic       cfg_bad, cfg_ok, last_sec, idle;

    assign idle     = (state_q == StIdle);
    assign cfg_sec  = cfg_addr[5:3];
    assign cfg_idx  = cfg_addr[2:0];
    assign cfg_bad  = !idle || (32'(cfg_sec) >= NSEC) || (cfg_idx == IDX_BAD);
    assign cfg_ok   = cfg_we && !cfg_bad;
    assign last_sec = (sec_q == 3'(NSEC - 1));

    always_comb begin
        cur_coef = '{default: '0};
        cur_shr  = '0;
        cur_shl  = '0;
        cur_x1   = '0;
        cur_x2   = '0;
        cur_y1   = '0;
        cur_y2   = '0;
        for (int s = 0; s < int'(NSEC); s++) begin
            if (sec_q == 3'(s)) begin
                cur_coef = coef_q[s];
                cur_shr  = shr_q[s];
                cur_shl  = shl_q[s];
                cur_x1   = x1_q[s];
                cur_x2   = x2_q[s];
                cur_y1   = y1_q[s];
                cur_y2   = y2_q[s];
            end
        end
    end

    // Tap order a0*x, a1*x1, a2*x2, then the two feedback terms subtracted.
    always_comb begin
        mac_coef = '0;
        mac_data = '0;
        case (tap_q)
            3'd0: begin mac_coef = cur_coef[0]; mac_data = sec_in_q; end
            3'd1: begin mac_coef = cur_coef[1]; mac_data = cur_x1;   end
            3'd2: begin mac_coef = cur_coef[2]; mac_data = cur_x2;   end
            3'd3: begin mac_coef = cur_coef[3]; mac_data = cur_y1;   end
            3'd4: begin mac_coef = cur_coef[4]; mac_data = cur_y2;   end
            default: ;
        endcase
        mac_en  = (state_q == StMac);
        mac_clr = (tap_q == 3'd0);
        mac_sub = (tap_q >= 3'd3);
    end

    iir_mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (mac_en),
        .clr  (mac_clr),
        .sub  (mac_sub),
        .coef (mac_coef),
        .data (mac_data),
        .acc  (acc)
    );

    assign y_wb   = DW'(acc >>> cur_shr);
    assign out_wb = y_wb << cur_shl;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (sample_valid) state_d = StMac;
            StMac:  if (tap_q == 3'(NUM_TAPS - 1)) state_d = StWb;
            StWb:   state_d = last_sec ? StDone : StMac;
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            sec_q     <= '0;
            sec_in_q  <= '0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= sample_valid && !idle;
            cfg_err_q <= cfg_we && cfg_bad;
            unique case (state_q)
                StIdle: begin
                    tap_q <= '0;
                    sec_q <= '0;
                    if (sample_valid) sec_in_q <= din;
                end
                StMac: tap_q <= (tap_q == 3'(NUM_TAPS - 1)) ? 3'd0 : tap_q + 3'd1;
                StWb: begin
                    sec_in_q <= out_wb;
                    sec_q    <= sec_q + 3'd1;
                    if (last_sec) dout_q <= out_wb;
                end
                StDone: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(NSEC); s++) begin
                coef_q[s] <= '{default: '0};
                shr_q[s]  <= '0;
                shl_q[s]  <= '0;
            end
        end else if (cfg_ok) begin
            for (int s = 0; s < int'(NSEC); s++) begin
                if (cfg_sec == 3'(s)) begin
                    if (cfg_idx == IDX_SHR) begin
                        shr_q[s] <= cfg_wdata[4:0];
                    end else if (cfg_idx == IDX_SHL) begin
                        shl_q[s] <= cfg_wdata[3:0];
                    end else begin
                        coef_q[s][cfg_idx] <= cfg_wdata;
                    end
                end
            end
        end
    end

    // History holds pre-shl y so the feedback gain is independent of output scaling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(NSEC); s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (idle && hist_clr) begin
            for (int s = 0; s < int'(NSEC); s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (state_q == StWb) begin
            for (int s = 0; s < int'(NSEC); s++) begin
                if (sec_q == 3'(s)) begin
                    x2_q[s] <= x1_q[s];
                    x1_q[s] <= sec_in_q;
                    y2_q[s] <= y1_q[s];
                    y1_q[s] <= y_wb;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == StDone);
    assign busy       = !idle;
    assign overrun    = overrun_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_iir_biquad_sched.sv
// Directed bench for iir_biquad_sched with NSEC=2; expected values hand-computed.
module tb_iir_biquad_sched;

    localparam logic [2:0] A0 = 3'd0, A1 = 3'd1, A2 = 3'd2, B1 = 3'd3, B2 = 3'd4;
    localparam logic [2:0] SHR = 3'd5, SHL = 3'd6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] din = '0;
    logic signed [15:0] dout;
    logic               dout_valid, busy, overrun, cfg_err;
    logic               cfg_we = 1'b0;
    logic [5:0]         cfg_addr = '0;
    logic [15:0]        cfg_wdata = '0;
    logic               hist_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iir_biquad_sched #(
        .NSEC  (2),
        .DW    (16),
        .ACC_W (36)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .din          (din),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .overrun      (overrun),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_err      (cfg_err),
        .hist_clr     (hist_clr)
    );

    task automatic cfg_write(input logic [2:0] sec, input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = {sec, idx};
        cfg_wdata = val;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic set_pass(input logic [2:0] sec);
        cfg_write(sec, A0, 16'd16384);
        cfg_write(sec, A1, 16'd0);
        cfg_write(sec, A2, 16'd0);
        cfg_write(sec, B1, 16'd0);
        cfg_write(sec, B2, 16'd0);
        cfg_write(sec, SHR, 16'd14);
        cfg_write(sec, SHL, 16'd0);
    endtask

    // Returns dout at the dout_valid cycle, its latency in cycles after T, and busy-cycle count.
    task automatic run_sample(input logic signed [15:0] x, input bit clr,
                              output logic signed [15:0] y, output int lat, output int busy_n);
        @(negedge clk);
        sample_valid = 1'b1;
        din          = x;
        hist_clr     = clr;
        @(negedge clk);
        sample_valid = 1'b0;
        hist_clr     = 1'b0;
        lat          = 1;
        busy_n       = 0;
        while (!dout_valid && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_n++;
        y = dout;
        n_cmp++;
        if (dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL dout_valid_timeout: got %b required 1 within 40 cycles", dout_valid);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dout, dout_valid, busy, overrun, cfg_err} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got dout=%0d dv=%b busy=%b ov=%b ce=%b required all 0",
                     dout, dout_valid, busy, overrun, cfg_err);
        end
        rst = 1'b1;
    endtask

    task automatic test_passthrough;
        logic signed [15:0] y;
        int lat, bn;
        set_pass(3'd0);
        set_pass(3'd1);
        run_sample(16'sd1000, 1'b1, y, lat, bn);
        n_cmp++;
        if (y !== 16'sd1000) begin
            n_bad++; $display("FAIL pass_dout: got %0d required 1000", y);
        end
        n_cmp++;
        if (lat != 13) begin
            n_bad++; $display("FAIL pass_latency: got %0d required 13", lat);
        end
        n_cmp++;
        if (bn != 13) begin
            n_bad++; $display("FAIL pass_busy_cycles: got %0d required 13", bn);
        end
        @(negedge clk);
        n_cmp++;
        if ({dout_valid, busy} !== 2'b00 || dout !== 16'sd1000) begin
            n_bad++;
            $display("FAIL pass_after_done: got dv=%b busy=%b dout=%0d required 0 0 1000",
                     dout_valid, busy, dout);
        end
    endtask

    task automatic test_feedback;
        logic signed [15:0] exp_seq [5] = '{16'sd1000, 16'sd500, 16'sd250, 16'sd125, 16'sd62};
        logic signed [15:0] y;
        int lat, bn;
        cfg_write(3'd0, B1, 16'hE000);
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 16'sd1000 : 16'sd0, (i == 0), y, lat, bn);
            n_cmp++;
            if (y !== exp_seq[i]) begin
                n_bad++; $display("FAIL feedback_%0d: got %0d required %0d", i, y, exp_seq[i]);
            end
        end
        // Clear and sample in the same cycle: must see zero history, not 1000 + 31.
        run_sample(16'sd1000, 1'b1, y, lat, bn);
        n_cmp++;
        if (y !== 16'sd1000) begin
            n_bad++; $display("FAIL feedback_clr_same_cycle: got %0d required 1000", y);
        end
        cfg_write(3'd0, B1, 16'd0);
    endtask

    task automatic test_trunc_shl;
        logic signed [15:0] y;
        int lat, bn;
        cfg_write(3'd0, A0, 16'd32767);
        cfg_write(3'd0, SHR, 16'd0);
        run_sample(16'sd2, 1'b1, y, lat, bn);
        n_cmp++;
        if (y !== -16'sd2) begin
            n_bad++; $display("FAIL trunc_wrap: got %0d required -2", y);
        end
        cfg_write(3'd0, A0, 16'd16384);
        cfg_write(3'd0, SHR, 16'd14);
        cfg_write(3'd1, SHL, 16'd1);
        run_sample(16'sd1000, 1'b1, y, lat, bn);
        n_cmp++;
        if (y !== 16'sd2000) begin
            n_bad++; $display("FAIL shl_one: got %0d required 2000", y);
        end
        cfg_write(3'd1, SHL, 16'd0);
    endtask

    task automatic test_overrun;
        logic signed [15:0] y;
        int lat, bn, k, ov_cnt, ov_first;
        cfg_write(3'd0, A1, 16'd16384);
        cfg_write(3'd0, A2, 16'd16384);
        @(negedge clk);
        sample_valid = 1'b1;
        din          = 16'sd1000;
        hist_clr     = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        hist_clr     = 1'b0;
        k = 1; ov_cnt = 0; ov_first = 0;
        while (k < 40) begin
            if (overrun) begin
                ov_cnt++;
                if (ov_first == 0) ov_first = k;
            end
            if (dout_valid) break;
            sample_valid = (k == 4);
            din          = 16'sd3000;
            @(negedge clk);
            k++;
        end
        sample_valid = 1'b0;
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 16'sd1000 || k != 13) begin
            n_bad++;
            $display("FAIL overrun_result: got dv=%b dout=%0d at %0d required 1 1000 at 13",
                     dout_valid, dout, k);
        end
        n_cmp++;
        if (ov_cnt != 1 || ov_first != 5) begin
            n_bad++;
            $display("FAIL overrun_pulse: got count=%0d first=%0d required 1 at 5", ov_cnt, ov_first);
        end
        // y = x + x1 + x2; history must hold only the accepted 1000.
        run_sample(16'sd0, 1'b0, y, lat, bn);
        n_cmp++;
        if (y !== 16'sd1000) begin
            n_bad++; $display("FAIL overrun_hist_1: got %0d required 1000", y);
        end
        run_sample(16'sd0, 1'b0, y, lat, bn);
        n_cmp++;
        if (y !== 16'sd1000) begin
            n_bad++; $display("FAIL overrun_hist_2: got %0d required 1000", y);
        end
        cfg_write(3'd0, A1, 16'd0);
        cfg_write(3'd0, A2, 16'd0);
    endtask

    task automatic test_cfg_guard;
        int k;
        @(negedge clk);
        sample_valid = 1'b1;
        din          = 16'sd1000;
        hist_clr     = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        hist_clr     = 1'b0;
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = {3'd0, A0};
        cfg_wdata = 16'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_bad++; $display("FAIL cfg_err_busy: got %b required 1", cfg_err);
        end
        @(negedge clk);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL cfg_err_pulse_width: got %b required 0", cfg_err);
        end
        k = 4;
        while (!dout_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 16'sd1000) begin
            n_bad++;
            $display("FAIL cfg_busy_unchanged: got dv=%b dout=%0d required 1 1000", dout_valid, dout);
        end
        cfg_write(3'd0, 3'd7, 16'd5);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_bad++; $display("FAIL cfg_err_idx7: got %b required 1", cfg_err);
        end
        cfg_write(3'd2, A0, 16'd5);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_bad++; $display("FAIL cfg_err_section: got %b required 1", cfg_err);
        end
        cfg_write(3'd1, A0, 16'd16384);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL cfg_err_valid_write: got %b required 0", cfg_err);
        end
    endtask

    task automatic test_reset_midop;
        logic signed [15:0] y;
        int lat, bn, dv_cnt;
        @(negedge clk);
        sample_valid = 1'b1;
        din          = 16'sd1000;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || dout !== 16'sd1000) begin
            n_bad++; $display("FAIL midop_pre: got busy=%b dout=%0d required 1 1000", busy, dout);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({dout, dout_valid, busy, overrun, cfg_err} !== 20'd0) begin
            n_bad++;
            $display("FAIL midop_reset_outputs: got dout=%0d dv=%b busy=%b ov=%b ce=%b required all 0",
                     dout, dout_valid, busy, overrun, cfg_err);
        end
        dv_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (dout_valid) dv_cnt++;
        end
        n_cmp++;
        if (dv_cnt != 0) begin
            n_bad++; $display("FAIL midop_no_dout_valid: got %0d pulses required 0", dv_cnt);
        end
        // a1 exposes any sec0 x1 left over from the aborted sample.
        set_pass(3'd0);
        set_pass(3'd1);
        cfg_write(3'd0, A1, 16'd16384);
        run_sample(16'sd1000, 1'b0, y, lat, bn);
        n_cmp++;
        if (y !== 16'sd1000) begin
            n_bad++; $display("FAIL midop_after_release: got %0d required 1000", y);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_feedback();
        test_trunc_shl();
        test_overrun();
        test_cfg_guard();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
